// File: rtl/viterbi_acs_if.sv
// Symbol-in / decision-out bundle between the ACS stage and its neighbours.
interface viterbi_acs_if #(
   parameter int unsigned ERR_W = 16
);
   logic             enable_i;
   logic             valid_i;
   logic [1:0]       d_in;
   logic             valid_o;
   logic [7:0]       decision_o;
   logic [2:0]       best_state_o;
   logic [ERR_W-1:0] err_acc_o;

   modport master (
      output enable_i, valid_i, d_in,
      input  valid_o, decision_o, best_state_o, err_acc_o
   );

   modport slave (
      input  enable_i, valid_i, d_in,
      output valid_o, decision_o, best_state_o, err_acc_o
   );
endinterface

// File: rtl/viterbi_acs.sv
// Add-compare-select for the 8-state rate-1/2 code: updates eight normalised
// path metrics per hard-decision symbol and emits survivor decisions.
module viterbi_acs #(
   parameter int unsigned PM_W    = 6,
   parameter int unsigned INIT_PM = 16,
   parameter int unsigned ERR_W   = 16
) (
   input  logic           clk,
   input  logic           rst,
   viterbi_acs_if.slave   bus
);
   localparam int unsigned CW = PM_W + 2;
   localparam logic [CW-1:0] PM_MAX = CW'({PM_W{1'b1}});

   // Branch outputs into state n (n7 in the MSBs): OUT0 from p0, OUT1 from p1.
   localparam logic [15:0] OUT0 = 16'b00_01_10_11_11_10_01_00;
   localparam logic [15:0] OUT1 = 16'b11_10_01_00_00_01_10_11;

   logic [PM_W-1:0]  pm      [8];
   logic [PM_W-1:0]  pm_nxt  [8];
   logic [CW-1:0]    sum_c   [8];
   logic [7:0]       dec_c;
   logic [CW-1:0]    m_c;
   logic [2:0]       best_c;
   logic [ERR_W-1:0] err_nxt;
   logic [ERR_W:0]   err_sum;
   logic [2:0]       p0;
   logic [2:0]       p1;
   logic [1:0]       bm0;
   logic [1:0]       bm1;
   logic [CW-1:0]    cand0;
   logic [CW-1:0]    cand1;
   logic [CW-1:0]    diff;

   function automatic logic [1:0] ham2(input logic [1:0] x);
      return {1'b0, x[1]} + {1'b0, x[0]};
   endfunction

   always_comb begin
      p0      = '0;
      p1      = '0;
      bm0     = '0;
      bm1     = '0;
      cand0   = '0;
      cand1   = '0;
      diff    = '0;
      dec_c   = '0;
      best_c  = '0;
      for (int n = 0; n < 8; n++) begin
         sum_c[n]  = '0;
         pm_nxt[n] = '0;
      end

      for (int n = 0; n < 8; n++) begin
         p0       = 3'(2 * (n % 4));
         p1       = p0 + 3'd1;
         bm0      = ham2(bus.d_in ^ OUT0[n*2 +: 2]);
         bm1      = ham2(bus.d_in ^ OUT1[n*2 +: 2]);
         cand0    = CW'(pm[p0]) + CW'(bm0);
         cand1    = CW'(pm[p1]) + CW'(bm1);
         dec_c[n] = (cand1 < cand0);
         sum_c[n] = (cand1 < cand0) ? cand1 : cand0;
      end

      m_c = sum_c[0];
      for (int n = 1; n < 8; n++) begin
         if (sum_c[n] < m_c) m_c = sum_c[n];
      end

      // Descending scan so the lowest matching index wins.
      for (int n = 7; n >= 0; n--) begin
         if (sum_c[n] == m_c) best_c = 3'(n);
      end

      for (int n = 0; n < 8; n++) begin
         diff      = sum_c[n] - m_c;
         pm_nxt[n] = (diff > PM_MAX) ? PM_W'(PM_MAX) : PM_W'(diff);
      end

      err_sum = (ERR_W+1)'(bus.err_acc_o) + (ERR_W+1)'(m_c);
      err_nxt = err_sum[ERR_W] ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pm[0] <= '0;
         for (int n = 1; n < 8; n++) pm[n] <= PM_W'(INIT_PM);
         bus.valid_o      <= 1'b0;
         bus.decision_o   <= '0;
         bus.best_state_o <= '0;
         bus.err_acc_o    <= '0;
      end else if (!bus.enable_i) begin
         pm[0] <= '0;
         for (int n = 1; n < 8; n++) pm[n] <= PM_W'(INIT_PM);
         bus.valid_o   <= 1'b0;
         bus.err_acc_o <= '0;
      end else begin
         bus.valid_o <= bus.valid_i;
         if (bus.valid_i) begin
            for (int n = 0; n < 8; n++) pm[n] <= pm_nxt[n];
            bus.decision_o   <= dec_c;
            bus.best_state_o <= best_c;
            bus.err_acc_o    <= err_nxt;
         end
      end
   end
endmodule

// File: tb/tb_viterbi_acs.sv
// Scoreboard bench for viterbi_acs: directed symbol streams with hand-derived results.
module tb_viterbi_acs;
   localparam int unsigned ERR_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   viterbi_acs_if #(.ERR_W(ERR_W)) bus ();

   viterbi_acs #(.PM_W(6), .INIT_PM(16), .ERR_W(ERR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [7:0]       dec;
      logic [7:0]       mask;
      logic [2:0]       best;
      logic [ERR_W-1:0] err;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_out    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every valid_o must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid_o: valid_o=1 with no symbol outstanding");
         end else begin
            e = sb.pop_front();
            n_out++;
            chk("decision", 32'(bus.decision_o & e.mask), 32'(e.dec & e.mask));
            chk("best_state", 32'(bus.best_state_o), 32'(e.best));
            chk("err_acc", 32'(bus.err_acc_o), 32'(e.err));
         end
      end
   end

   task automatic set_in(input logic en, input logic v, input logic [1:0] d);
      bus.enable_i = en;
      bus.valid_i  = v;
      bus.d_in     = d;
   endtask

   task automatic send(input logic [1:0] d, input logic [7:0] dec, input logic [7:0] mask,
                       input logic [2:0] best, input logic [ERR_W-1:0] err);
      exp_t x;
      set_in(1'b1, 1'b1, d);
      x.dec = dec; x.mask = mask; x.best = best; x.err = err;
      sb.push_back(x);
      @(negedge clk);
   endtask

   task automatic idle();
      set_in(1'b1, 1'b0, 2'b00);
      @(negedge clk);
   endtask

   task automatic check_hold(input string tag, input logic [7:0] dec, input logic [2:0] best,
                             input logic [ERR_W-1:0] err);
      chk({tag, "_valid_o"}, 32'(bus.valid_o), 32'd0);
      chk({tag, "_decision"}, 32'(bus.decision_o), 32'(dec));
      chk({tag, "_best_state"}, 32'(bus.best_state_o), 32'(best));
      chk({tag, "_err_acc"}, 32'(bus.err_acc_o), 32'(err));
   endtask

   task automatic drain();
      for (int i = 0; i < 16 && sb.size() != 0; i++) idle();
      idle();
      chk("drain_outstanding", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(1'b1, 1'b0, 2'b00);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      set_in(1'b0, 1'b0, 2'b00);

      // Reset and idle hold
      do_reset();
      for (int i = 0; i < 3; i++) begin
         idle();
         check_hold("reset", 8'h00, 3'd0, '0);
      end

      // All-zero stream: state 0 survives with zero error
      send(2'b00, 8'h08, 8'hFF, 3'd0, '0);
      send(2'b00, 8'h2A, 8'hFF, 3'd0, '0);
      for (int i = 0; i < 8; i++) send(2'b00, 8'h00, 8'h01, 3'd0, '0);
      drain();

      // Clean stream from encoder input 1,0,1,1
      do_reset();
      send(2'b11, 8'h80, 8'hFF, 3'd4, '0);
      send(2'b10, 8'h8A, 8'hFF, 3'd2, '0);
      send(2'b01, 8'h00, 8'hFF, 3'd1, '0);
      send(2'b11, 8'hF7, 8'hFF, 3'd0, '0);
      drain();

      // Third symbol corrupted; several ties on the last step
      do_reset();
      send(2'b11, 8'h80, 8'hFF, 3'd4, 16'd0);
      send(2'b10, 8'h8A, 8'hFF, 3'd2, 16'd0);
      send(2'b00, 8'h00, 8'hFF, 3'd1, 16'd1);
      send(2'b11, 8'hC5, 8'hFF, 3'd0, 16'd1);

      // enable_i dropped (with valid_i high): metrics and err reset, decisions held
      set_in(1'b0, 1'b1, 2'b00);
      @(negedge clk);
      check_hold("enable_drop", 8'hC5, 3'd0, 16'd0);
      send(2'b11, 8'h80, 8'hFF, 3'd4, 16'd0);
      drain();

      // Gaps between symbols must not disturb the result
      do_reset();
      send(2'b11, 8'h80, 8'hFF, 3'd4, '0);
      idle();
      check_hold("gap1", 8'h80, 3'd4, '0);
      idle();
      check_hold("gap2", 8'h80, 3'd4, '0);
      send(2'b10, 8'h8A, 8'hFF, 3'd2, '0);
      drain();

      chk("output_count", 32'(n_out), 32'd21);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
